// File: rtl/game_timer_pkg.sv
// Purpose : shared widths, limits and FSM encoding for the round timer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package game_timer_pkg;

    localparam int GAME_TIME_W = 12;
    localparam int MIN_W       = 6;
    localparam int SEC_W       = 6;
    localparam int MAX_SECONDS = 59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    // Output layout is {minutes, seconds}, both plain binary.
    function automatic logic [GAME_TIME_W-1:0] pack_time(
        input logic [MIN_W-1:0] minutes,
        input logic [SEC_W-1:0] seconds
    );
        return {minutes, seconds};
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Purpose : prescaler counting 0..DIV-1 while enabled; registered tick on wrap.
// Latency : tick is high the cycle after the terminal count; tc is the same-cycle strobe.
// Backpressure: none; en low holds the count, clr zeroes it.
//
// Ports:
//   pclk  in  clock
//   rst   in  synchronous active-high reset
//   en    in  advance the count this cycle
//   clr   in  zero the count (wins over en)
//   tick  out registered 1-cycle pulse after each wrap
//   tc    out combinational terminal-count strobe, lets the parent update
//             its counter on the same edge that raises tick
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic pclk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic tc
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    assign tc   = en && !clr && (r_cnt == LAST);
    assign tick = r_tick;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= tc;
            if (clr) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= tc ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_timer.sv
// Purpose : elapsed play time of one round as {minutes, seconds}, saturating at MAX_MINUTES:59.
// Latency : game_time and sec_tick update together, one cycle after the prescaler terminal count.
// Backpressure: none; pause holds the prescaler and time, stop freezes the time.
//
// Ports:
//   pclk       in  clock
//   rst        in  synchronous active-high reset
//   start      in  pulse: clear time and (re)start counting, from any state
//   pause      in  level: hold counting while high (only acts in RUN)
//   stop       in  pulse: freeze the time
//   game_time  out {minutes[11:6], seconds[5:0]}
//   running    out high in RUN only
//   sec_tick   out 1-cycle pulse per counted second
//   saturated  out sticky, set when MAX_MINUTES:59 is reached
module game_timer
    import game_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 65_000_000,
    parameter int MAX_MINUTES = 59
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   stop,
    output logic [GAME_TIME_W-1:0] game_time,
    output logic                   running,
    output logic                   sec_tick,
    output logic                   saturated
);

    localparam logic [MIN_W-1:0] MIN_LAST     = MIN_W'(MAX_MINUTES);
    localparam logic [SEC_W-1:0] SEC_LAST     = SEC_W'(MAX_SECONDS);
    localparam logic [SEC_W-1:0] SEC_PRE_LAST = SEC_W'(MAX_SECONDS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MIN_W-1:0] r_min;
    logic [SEC_W-1:0] r_sec;
    logic             r_saturated;

    logic w_clear;
    logic w_count_en;
    logic w_tc;
    logic w_tick;
    logic w_last;

    // start restarts the round from every state, so it is the clear on its own.
    assign w_clear = start;

    // Counting happens only in a RUN cycle with no higher-priority control;
    // a stop coinciding with a terminal count therefore discards that second.
    assign w_count_en = (r_state == ST_RUN) && !start && !stop && !pause;

    // The increment about to happen lands on the saturation point.
    assign w_last = (r_min == MIN_LAST) && (r_sec == SEC_PRE_LAST);

    tick_divider #(
        .DIV (CLK_FREQ_HZ)
    ) u_tick_divider (
        .pclk (pclk),
        .rst  (rst),
        .en   (w_count_en),
        .clr  (w_clear),
        .tick (w_tick),
        .tc   (w_tc)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start)                w_state_nxt = ST_RUN;
                else if (stop)            w_state_nxt = ST_FROZEN;
                else if (pause)           w_state_nxt = ST_PAUSE;
                else if (w_tc && w_last)  w_state_nxt = ST_FROZEN;
            end
            ST_PAUSE: begin
                if (start)       w_state_nxt = ST_RUN;
                else if (stop)   w_state_nxt = ST_FROZEN;
                else if (!pause) w_state_nxt = ST_RUN;
            end
            ST_FROZEN: begin
                if (start) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst || w_clear) begin
            r_min       <= '0;
            r_sec       <= '0;
            r_saturated <= 1'b0;
        end else if (w_tc) begin
            if (r_sec == SEC_LAST) begin
                r_sec <= '0;
                r_min <= r_min + 1'b1;
            end else begin
                r_sec <= r_sec + 1'b1;
            end
            if (w_last) r_saturated <= 1'b1;
        end
    end

    assign game_time = pack_time(r_min, r_sec);
    assign running   = (r_state == ST_RUN);
    assign sec_tick  = w_tick;
    assign saturated = r_saturated;

endmodule
